aes_inv_cipher_iter: RTL and testbench

Iterative AES-128 inverse cipher (FIPS-197 InvCipher). It computes one round per clock and turns a 128-bit ciphertext back into plaintext.
It is the decrypt counterpart of the existing forward Cipher and uses the same expanded key schedule from KeyExpansion, with the round keys applied in reverse order.
A start/busy/done handshake lets a controller or bench sequence blocks.

---
 rtl/aes_pkg.sv | 108 ++++++++++
 rtl/aes_inv_round.sv | 19 +
 rtl/aes_inv_cipher_iter.sv | 95 +++++++++
 tb/tb_aes_inv_cipher_iter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: constants, inverse S-box, GF(2^8) helpers and the
// inverse round transforms. State layout: byte i at bits [8i:8i+7], column c = bytes 4c..4c+3.
`default_nettype none

package aes_pkg;

    localparam int NB   = 4;
    localparam int NK   = 4;
    localparam int NR   = 10;
    localparam int KEYW = 128 * (NR + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        logic [7:0] x2;
        x2 = xtime(b);
        return xtime(xtime(x2)) ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        logic [7:0] x4;
        x4 = xtime(xtime(b));
        return xtime(x4) ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x4;
        x2 = xtime(b);
        x4 = xtime(x2);
        return xtime(x4) ^ x4 ^ x2;
    endfunction

    function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
        logic [0:127] o;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = INV_SBOX[8*int'(s[8*i +: 8]) +: 8];
        end
        return o;
    endfunction

    // Row r rotates right by r columns.
    function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
        logic [0:127] o;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c + r) +: 8] = s[8*(4*((c - r + 4) % 4) + r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < NB; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3);
            o[32*c + 8  +: 8] = gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3);
            o[32*c + 16 +: 8] = gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3);
            o[32*c + 24 +: 8] = gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3);
        end
        return o;
    endfunction

    function automatic logic [0:127] rk(input logic [0:KEYW-1] words, input logic [3:0] r);
        return words[128*int'(r) +: 128];
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; the final round skips InvMixColumns.
`default_nettype none

module aes_inv_round (
    input  logic [0:127] st,
    input  logic [0:127] rk,
    input  logic         last,
    output logic [0:127] next_st
);
    import aes_pkg::*;

    logic [0:127] w_keyed;

    assign w_keyed = inv_sub_bytes(inv_shift_rows(st)) ^ rk;
    assign next_st = last ? w_keyed : inv_mix_columns(w_keyed);

endmodule

`default_nettype wire

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher, one round per clock, start/busy/done handshake.
`default_nettype none

module aes_inv_cipher_iter #(
    parameter int NR   = 10,
    parameter int KEYW = 128 * (NR + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [0:127]    in,
    input  logic [0:KEYW-1] words,
    output logic [0:127]    out,
    output logic            busy,
    output logic            done
);
    import aes_pkg::*;

    if (NR != NK + 6 || KEYW != 128 * (NR + 1)) begin : g_bad_params
        $error("aes_inv_cipher_iter: only NR=10 (AES-128) is supported");
    end

    state_t       r_state;
    state_t       w_state_nxt;
    logic [0:127] r_st;
    logic [3:0]   r_rnd;
    logic [0:127] w_rk;
    logic [0:127] w_rk_first;
    logic [0:127] w_next_st;
    logic         w_last;

    // In FINAL the counter has already reached 0, so w_rk selects rk(0).
    assign w_rk       = rk(words, r_rnd);
    assign w_rk_first = rk(words, 4'(NR));
    assign w_last     = (r_state == S_FINAL);

    aes_inv_round u_round (
        .st      (r_st),
        .rk      (w_rk),
        .last    (w_last),
        .next_st (w_next_st)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_ROUND;
            S_ROUND: if (r_rnd == 4'd1) w_state_nxt = S_FINAL;
            S_FINAL: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st  <= '0;
            r_rnd <= '0;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_st  <= in ^ w_rk_first;
                        r_rnd <= 4'(NR - 1);
                        busy  <= 1'b1;
                    end
                end
                S_ROUND: begin
                    r_st  <= w_next_st;
                    r_rnd <= r_rnd - 4'd1;
                end
                S_FINAL: begin
                    out  <= w_next_st;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for aes_inv_cipher_iter; plaintexts come from an independent forward-cipher model.
`default_nettype none
`timescale 1ns/1ps

module tb_aes_inv_cipher_iter;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [127:0]  in_w  = '0;
    logic [0:1407] words = '0;
    logic [127:0]  out_w;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int busy_cnt  = 0;
    int last_done = 0;

    logic [127:0] sb_exp[$];
    int           sb_cyc[$];
    logic [7:0]   sbox_t[256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_inv_cipher_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in    (in_w),
        .words (words),
        .out   (out_w),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box derived from the GF inverse plus affine map, not copied from a table.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [0:1407] key_expand(input logic [127:0] key);
        logic [31:0]   w[44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1407] kw;
        rc = 8'h01;
        for (int i = 0; i < 44; i++) begin
            if (i < 4) begin
                w[i] = key[127-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % 4 == 0) begin
                    t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]}
                        ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end
                w[i] = w[i-4] ^ t;
            end
            kw[32*i +: 32] = w[i];
        end
        return kw;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [0:1407] kw);
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ kw[8*i +: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c+row] = sbox_t[s[4*((c+row)%4)+row]];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ kw[128*r + 8*i +: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt = busy_cnt + 1;
            if (done) begin
                check("done_expected", 128'(sb_exp.size() != 0), 128'd1);
                if (sb_exp.size() != 0) begin
                    check("plaintext", out_w, sb_exp.pop_front());
                    check("latency", 128'(cyc - sb_cyc.pop_front()), 128'd10);
                    check("busy_cycles", 128'(busy_cnt), 128'd10);
                end
                busy_cnt  = 0;
                last_done = cyc;
            end
        end
    end

    task automatic start_op(input logic [0:1407] kw, input logic [127:0] ct, input logic [127:0] pt);
        words = kw;
        in_w  = ct;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sb_exp.push_back(pt);
        sb_cyc.push_back(cyc);
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while (sb_exp.size() != 0 && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb_exp.size() != 0) begin
            check("drain_timeout", 128'(sb_exp.size()), 128'd0);
            sb_exp.delete();
            sb_cyc.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:1407] kw1;
        logic [0:1407] kw2;
        logic [0:1407] kwr;
        logic [127:0]  key;
        logic [127:0]  pt;
        int            first_done;
        int            n;

        build_sbox();
        kw1 = key_expand(KEY1);
        kw2 = key_expand(KEY2);
        check("model_c1", encrypt(PT1, kw1), CT1);
        check("model_appb", encrypt(PT2, kw2), CT2);

        repeat (3) @(posedge clk); #1;
        check("reset_out", out_w, 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        start_op(kw1, CT1, PT1);
        wait_drain(20);
        start_op(kw2, CT2, PT2);
        wait_drain(20);

        // Back-to-back: second start raised while done is high.
        start_op(kw1, CT1, PT1);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_first_done", 128'(done), 128'd1);
        first_done = cyc;
        start_op(kw2, CT2, PT2);
        wait_drain(30);
        check("b2b_gap", 128'(last_done - first_done), 128'd11);

        // start held high with in changing mid-operation.
        words = kw2;
        in_w  = CT2;
        start = 1'b1;
        @(posedge clk); #1;
        sb_exp.push_back(PT2);
        sb_cyc.push_back(cyc);
        for (int i = 0; i < 8; i++) begin
            in_w = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_drain(20);
        repeat (15) @(posedge clk); #1;
        check("held_out_stable", out_w, PT2);

        // Reset in the middle of a block.
        start_op(kw1, CT1, PT1);
        repeat (5) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out", out_w, 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_done", 128'(done), 128'd0);
        sb_exp.delete();
        sb_cyc.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (15) @(posedge clk); #1;
        check("abort_no_update", out_w, 128'd0);
        start_op(kw1, CT1, PT1);
        wait_drain(20);

        for (int i = 0; i < 100; i++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            kwr = key_expand(key);
            start_op(kwr, encrypt(pt, kwr), pt);
            wait_drain(20);
        end

        repeat (3) @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
